multi_debounce_counter: RTL and testbench

Parametrised N-channel push-button front end: per-channel two-flop synchroniser, stable-time debouncer, mode-selectable edge detector and event counter. It replaces the single-button debouncer/counter pair in the board top level and runs in the 10 MHz domain, with packed per-channel counts for display logic. Each channel adds a per-channel clear, overflow flag and wrap/saturate selection.

---
 rtl/debounce_pkg.sv | 25 ++
 rtl/debounce_channel.sv | 84 ++++++++
 rtl/multi_debounce_counter.sv | 47 ++++
 tb/tb_multi_debounce_counter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the push-button front end.
// Edge-mode encoding matches the two-bit edge_mode_i control field.
package debounce_pkg;

   typedef enum logic [1:0] {
      EDGE_RISE = 2'b00,
      EDGE_FALL = 2'b01,
      EDGE_BOTH = 2'b10,
      EDGE_NONE = 2'b11
   } edge_mode_e;

   // 1 ms hold time at a 10 MHz core clock
   localparam int STABLE_CYCLES_10MHZ = 10000;

   // True when a debounced transition to new_level should raise an event.
   function automatic logic edge_match(input edge_mode_e mode, input logic new_level);
      case (mode)
         EDGE_RISE: return new_level;
         EDGE_FALL: return !new_level;
         EDGE_BOTH: return 1'b1;
         default:   return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop sync, stable-time debounce, edge strobe, event counter.
// level/pulse move STABLE_CYCLES+2 edges after btn settles, count one edge later; no backpressure.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = STABLE_CYCLES_10MHZ,
   parameter int CNT_W         = 8,
   parameter int SATURATE      = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             btn,
   input  edge_mode_e       edge_mode,
   input  logic             clr,
   output logic             level,
   output logic             pulse,
   output logic [CNT_W-1:0] count,
   output logic             ovf
);

   localparam int              DB_W   = $clog2(STABLE_CYCLES);
   localparam logic [DB_W-1:0] DB_MAX = DB_W'(STABLE_CYCLES - 1);

   logic            sync_meta;
   logic            sync;
   logic [DB_W-1:0] db_cnt;
   logic            toggle;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta <= 1'b0;
         sync      <= 1'b0;
      end else begin
         sync_meta <= btn;
         sync      <= sync_meta;
      end
   end

   assign toggle = (sync != level) && (db_cnt == DB_MAX);

   // Any return of sync to the current level restarts the qualification window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_cnt <= '0;
         level  <= 1'b0;
      end else if (sync == level) begin
         db_cnt <= '0;
      end else if (toggle) begin
         db_cnt <= '0;
         level  <= ~level;
      end else begin
         db_cnt <= db_cnt + 1'b1;
      end
   end

   // Mode is looked at only when level actually flips, so mode changes alone never strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pulse <= 1'b0;
      end else begin
         pulse <= toggle && edge_match(edge_mode, ~level);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         ovf   <= 1'b0;
      end else if (clr) begin
         count <= '0;
         ovf   <= 1'b0;
      end else if (pulse) begin
         if (&count) begin
            ovf <= 1'b1;
            if (SATURATE == 0) begin
               count <= '0;
            end
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/multi_debounce_counter.sv
// N independent debounced button channels with packed per-channel event counts.
// Latency is that of debounce_channel; free-running, no backpressure.
module multi_debounce_counter
   import debounce_pkg::*;
#(
   parameter int N_CH          = 4,
   parameter int STABLE_CYCLES = STABLE_CYCLES_10MHZ,
   parameter int CNT_W         = 8,
   parameter int SATURATE      = 0
) (
   input  logic                  clk,
   input  logic                  rst_n_i,
   input  logic [N_CH-1:0]       btn_i,
   input  logic [1:0]            edge_mode_i,
   input  logic [N_CH-1:0]       clr_i,
   output logic [N_CH-1:0]       level_o,
   output logic [N_CH-1:0]       pulse_o,
   output logic [N_CH*CNT_W-1:0] count_o,
   output logic [N_CH-1:0]       ovf_o
);

   edge_mode_e       mode;
   logic [CNT_W-1:0] ch_count [N_CH];

   assign mode = edge_mode_e'(edge_mode_i);

   for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
      debounce_channel #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .CNT_W         (CNT_W),
         .SATURATE      (SATURATE)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n_i),
         .btn       (btn_i[ch]),
         .edge_mode (mode),
         .clr       (clr_i[ch]),
         .level     (level_o[ch]),
         .pulse     (pulse_o[ch]),
         .count     (ch_count[ch]),
         .ovf       (ovf_o[ch])
      );

      assign count_o[ch*CNT_W +: CNT_W] = ch_count[ch];
   end

endmodule

// File: tb/tb_multi_debounce_counter.sv
// Directed bench: one wrapping and one saturating instance driven by the same stimulus.
module tb_multi_debounce_counter;

   localparam int N_CH   = 4;
   localparam int STABLE = 4;
   localparam int CNT_W  = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  btn;
   logic [3:0]  clr;
   logic [1:0]  mode;

   logic [3:0]  level, pulse, ovf;
   logic [11:0] count;
   logic [3:0]  s_level, s_pulse, s_ovf;
   logic [11:0] s_count;

   int checks = 0;
   int fails  = 0;
   int pulses [4];

   always #5 clk = ~clk;

   multi_debounce_counter #(
      .N_CH(N_CH), .STABLE_CYCLES(STABLE), .CNT_W(CNT_W), .SATURATE(0)
   ) dut_wrap (
      .clk(clk), .rst_n_i(rst_n), .btn_i(btn), .edge_mode_i(mode), .clr_i(clr),
      .level_o(level), .pulse_o(pulse), .count_o(count), .ovf_o(ovf)
   );

   multi_debounce_counter #(
      .N_CH(N_CH), .STABLE_CYCLES(STABLE), .CNT_W(CNT_W), .SATURATE(1)
   ) dut_sat (
      .clk(clk), .rst_n_i(rst_n), .btn_i(btn), .edge_mode_i(mode), .clr_i(clr),
      .level_o(s_level), .pulse_o(s_pulse), .count_o(s_count), .ovf_o(s_ovf)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 4; i++) pulses[i] += int'(pulse[i]);
      end
   endtask

   task automatic clear_pulses();
      for (int i = 0; i < 4; i++) pulses[i] = 0;
   endtask

   function automatic logic [2:0] cnt(input logic [11:0] v, input int ch);
      return v[ch*CNT_W +: CNT_W];
   endfunction

   task automatic press_release(input int ch, input int times);
      repeat (times) begin
         btn[ch] = 1'b1;
         step(8);
         btn[ch] = 1'b0;
         step(8);
      end
   endtask

   initial begin
      rst_n = 1'b1;
      btn   = 4'hF;
      clr   = 4'h0;
      mode  = 2'b00;
      clear_pulses();
      #2 rst_n = 1'b0;

      // reset with all buttons held
      step(3);
      check("rst_level", level, 4'h0);
      check("rst_pulse", pulse, 4'h0);
      check("rst_count", count, 12'h000);
      check("rst_ovf", ovf, 4'h0);
      check("rst_s_count", s_count, 12'h000);
      rst_n = 1'b1;
      step(5);
      check("prequal_level", level, 4'h0);
      step(1);
      check("qual_level", level, 4'hF);
      check("qual_pulse", pulse, 4'hF);
      step(1);
      check("qual_pulse_gone", pulse, 4'h0);
      check("qual_count", count, 12'h249);
      check("qual_s_count", s_count, 12'h249);

      // release in rising mode: level falls, no event
      btn = 4'h0;
      clear_pulses();
      step(6);
      check("fall_level", level, 4'h0);
      step(2);
      check("fall_no_pulse", pulses[0] + pulses[1] + pulses[2] + pulses[3], 0);
      check("fall_count", count, 12'h249);
      clr = 4'hF;
      step(1);
      clr = 4'h0;
      check("clr_all_count", count, 12'h000);
      check("clr_all_level", level, 4'h0);

      // glitch of 3 cycles rejected, then a held press accepted
      clear_pulses();
      btn[0] = 1'b1;
      step(3);
      btn[0] = 1'b0;
      step(10);
      check("glitch_level", level[0], 1'b0);
      check("glitch_pulses", pulses[0], 0);
      check("glitch_count", cnt(count, 0), 3'd0);
      btn[0] = 1'b1;
      step(6);
      check("held_level", level[0], 1'b1);
      check("held_pulse", pulse, 4'b0001);
      step(1);
      check("held_count", cnt(count, 0), 3'd1);
      btn[0] = 1'b0;
      step(8);

      // both-edge mode then falling mode on ch1
      mode = 2'b10;
      clear_pulses();
      press_release(1, 3);
      check("both_pulses", pulses[1], 6);
      check("both_count", cnt(count, 1), 3'd6);
      check("both_ovf", ovf[1], 1'b0);
      clr = 4'b0010;
      step(1);
      clr = 4'b0000;
      mode = 2'b01;
      clear_pulses();
      step(3);
      check("mode_change_no_pulse", pulses[1], 0);
      press_release(1, 3);
      check("fall_pulses", pulses[1], 3);
      check("fall_mode_count", cnt(count, 1), 3'd3);
      check("ch0_untouched", cnt(count, 0), 3'd1);

      // wrap versus saturate on ch2
      mode = 2'b00;
      press_release(2, 7);
      check("ch2_7_count", cnt(count, 2), 3'd7);
      check("ch2_7_ovf", ovf[2], 1'b0);
      check("ch2_7_s_count", cnt(s_count, 2), 3'd7);
      press_release(2, 1);
      check("ch2_8_wrap", cnt(count, 2), 3'd0);
      check("ch2_8_ovf", ovf[2], 1'b1);
      check("ch2_8_s_hold", cnt(s_count, 2), 3'd7);
      check("ch2_8_s_ovf", s_ovf[2], 1'b1);
      press_release(2, 1);
      check("ch2_9_count", cnt(count, 2), 3'd1);
      check("ch2_9_ovf", ovf[2], 1'b1);
      check("ch2_9_s_count", cnt(s_count, 2), 3'd7);

      // clear colliding with a due increment on ch3, ch0 counts normally
      press_release(3, 1);
      check("ch3_pre", cnt(count, 3), 3'd1);
      btn[3] = 1'b1;
      btn[0] = 1'b1;
      step(6);
      check("collide_pulse", pulse, 4'b1001);
      clr = 4'b1000;
      step(1);
      clr = 4'b0000;
      check("collide_ch3_count", cnt(count, 3), 3'd0);
      check("collide_ch3_ovf", ovf[3], 1'b0);
      check("collide_ch3_level", level[3], 1'b1);
      check("collide_ch0_count", cnt(count, 0), 3'd2);
      check("collide_ch2_count", cnt(count, 2), 3'd1);
      check("collide_ch2_ovf", ovf[2], 1'b1);
      btn = 4'h0;
      step(8);

      // reset in the middle of a qualification window
      btn[1] = 1'b1;
      step(4);
      rst_n = 1'b0;
      #1;
      check("midrst_level", level, 4'h0);
      check("midrst_count", count, 12'h000);
      check("midrst_ovf", ovf, 4'h0);
      check("midrst_s_count", s_count, 12'h000);
      step(2);
      rst_n = 1'b1;
      clear_pulses();
      step(5);
      check("requal_early_level", level, 4'h0);
      check("requal_early_pulses", pulses[1], 0);
      step(1);
      check("requal_level", level, 4'b0010);
      check("requal_pulse", pulse, 4'b0010);
      step(1);
      check("requal_count", count, 12'h008);
      check("requal_s_count", s_count, 12'h008);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
